// File: rtl/motor_pkg.sv
// Shared motor-drive types: FSM states, PWMx pair encodings and direction values.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic [1:0] PWM_COAST = 2'b00;
  localparam logic [1:0] PWM_FWD   = 2'b01;
  localparam logic [1:0] PWM_REV   = 2'b10;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running 0..PERIOD counter; flags the boundary cycle and pulses period_start after cnt==0.
module pwm_period_counter #(
  parameter int CNT_W  = 8,
  parameter int PERIOD = 255
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD);

  assign boundary = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + 1'b1;
      period_start <= (cnt == '0);
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Fixed-period PWM drive pair with boundary-only duty/direction updates and coast windows.
// Optional ramped duty on start-up when SOFT_START_EN is defined.
module pwm_generator
  import motor_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int PERIOD       = 255,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic [CNT_W-1:0] duty,
  output logic [1:0]       PWMx,
  output logic             period_start,
  output logic             busy
);

`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(PERIOD + 1);
  // Without soft start a full-scale step makes the ramp path collapse to target.
  localparam logic [CNT_W:0] STEP = SOFT ? (CNT_W+1)'(RAMP_STEP) : FULL;

  state_t          state, state_n;
  logic [DW-1:0]   dead_cnt, dead_n;
  logic [CNT_W:0]  duty_q, duty_n, target, base, duty_x;
  logic [CNT_W-1:0] cnt;
  logic            boundary, on, start;
  state_t          drive_st;

  pwm_period_counter #(.CNT_W(CNT_W), .PERIOD(PERIOD)) u_cnt (
    .clk          (clk),
    .reset        (reset),
    .cnt          (cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign duty_x   = {1'b0, duty};
  assign target   = (duty_x >= FULL) ? FULL : duty_x;
  assign drive_st = (dir == DIR_REV) ? REV : FWD;

  always_comb begin
    state_n = state;
    dead_n  = dead_cnt;
    case (state)
      IDLE: if (enable) state_n = drive_st;
      FWD, REV: begin
        if (!enable || drive_st != state) begin
          if (DEAD_PERIODS == 0) begin
            state_n = enable ? drive_st : IDLE;
          end else begin
            state_n = DEAD;
            dead_n  = DW'(DEAD_PERIODS - 1);
          end
        end
      end
      DEAD: begin
        if (dead_cnt != '0) dead_n  = dead_cnt - 1'b1;
        else                state_n = enable ? drive_st : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Ramp toward target from the current level (or from zero on a fresh start); drops apply at once.
  always_comb begin
    start = SOFT && (state == IDLE || state == DEAD) && (state_n == FWD || state_n == REV);
    base  = start ? '0 : duty_q;
    if (!start && target < duty_q)  duty_n = target;
    else if (target - base > STEP)  duty_n = base + STEP;
    else                            duty_n = target;
  end

  assign on   = ({1'b0, cnt} < duty_q);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dead_cnt <= '0;
      duty_q   <= '0;
      PWMx     <= PWM_COAST;
    end else begin
      if (boundary) begin
        state    <= state_n;
        dead_cnt <= dead_n;
        duty_q   <= duty_n;
      end
      PWMx <= {state == REV && on, state == FWD && on};
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: a period-level reference model predicts every output cycle.
module tb_pwm_generator;

  localparam int P  = 15;
  localparam int DP = 2;
  localparam int RS = 4;
`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] duty = 8'd0;
  logic [1:0] PWMx;
  logic       period_start;
  logic       busy;

  always #5 clk = ~clk;

  pwm_generator #(.CNT_W(8), .PERIOD(P), .DEAD_PERIODS(DP), .RAMP_STEP(RS)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .dir          (dir),
    .duty         (duty),
    .PWMx         (PWMx),
    .period_start (period_start),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0] pwm;
    logic       ps;
    logic       bsy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: drive mode (0 none, 1 fwd, 2 rev), remaining coast periods, and a cycle index.
  int m_cnt, m_duty, m_drive, m_coast;
  initial begin
    m_cnt = 0; m_duty = 0; m_drive = 0; m_coast = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_cnt = 0; m_duty = 0; m_drive = 0; m_coast = 0;
        q.delete();
      end else begin
        exp_t e;
        int want, tgt;
        bit started;
        e.pwm = (m_drive != 0 && m_cnt < m_duty) ? ((m_drive == 1) ? 2'b01 : 2'b10) : 2'b00;
        e.ps  = (m_cnt == 0);
        if (m_cnt == P) begin
          want    = enable ? (dir ? 2 : 1) : 0;
          tgt     = (int'(duty) > P) ? P + 1 : int'(duty);
          started = 1'b0;
          if (m_coast > 0) begin
            m_coast--;
            if (m_coast == 0) begin
              m_drive = want;
              started = (want != 0);
            end
          end else if (m_drive == 0) begin
            m_drive = want;
            started = (want != 0);
          end else if (want != m_drive) begin
            m_drive = 0;
            m_coast = DP;
          end
          if (!SOFT)                  m_duty = tgt;
          else if (started)           m_duty = (tgt < RS) ? tgt : RS;
          else if (tgt < m_duty)      m_duty = tgt;
          else if (tgt - m_duty > RS) m_duty = m_duty + RS;
          else                        m_duty = tgt;
        end
        e.bsy = (m_drive != 0 || m_coast != 0);
        m_cnt = (m_cnt + 1) % (P + 1);
        q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        chk("pwmx", int'(PWMx), int'(e.pwm));
        chk("period_start", int'(period_start), int'(e.ps));
        chk("busy", int'(busy), int'(e.bsy));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where period_start is high, i.e. cnt==1 in the DUT.
  task automatic wait_ps();
    int n = 0;
    @(negedge clk);
    while (!period_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("period_start_timeout", int'(n < 40), 1);
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_pwmx"}, int'(PWMx), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ps"}, int'(period_start), 0);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #1 check_reset_zero("reset_init");
    cycles(3);
    #2 reset = 1'b0;

    // Steady forward drive at duty 4.
    enable = 1'b1; dir = 1'b0; duty = 8'd4;
    cycles(4 * (P + 1));

    // Duty change mid-period at cnt==2.
    wait_ps();
    @(negedge clk);
    duty = 8'd12;
    cycles(3 * (P + 1));

    // Reversal through the coast window.
    duty = 8'd6;
    cycles(2 * (P + 1));
    dir = 1'b1;
    cycles(6 * (P + 1));

    // Zero duty and clamped over-range duty.
    dir = 1'b0; duty = 8'd0;
    cycles(6 * (P + 1));
    duty = 8'd200;
    cycles(3 * (P + 1));

    // Asynchronous reset during a high pulse.
    duty = 8'd6;
    cycles(2 * (P + 1));
    wait_ps();
    @(negedge clk);
    n = 0;
    while (PWMx == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_timeout", int'(n < 40), 1);
    #2 reset = 1'b1;
    #1 check_reset_zero("reset_mid");
    cycles(2);
    #2 reset = 1'b0;
    cycles(3 * (P + 1));

    // Start from idle with duty 12 (ramps when soft start is built in), then a drop to 2.
    enable = 1'b0;
    cycles(4 * (P + 1));
    enable = 1'b1; duty = 8'd12;
    cycles(5 * (P + 1));
    duty = 8'd2;
    cycles(2 * (P + 1));

    // Randomized commands at arbitrary times, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      cycles($urandom_range(1, 24));
      case ($urandom_range(0, 5))
        0:       enable = ~enable;
        1, 2:    dir = ~dir;
        3:       duty = 8'($urandom_range(0, 255));
        default: duty = 8'($urandom_range(0, P + 1));
      endcase
      if ($urandom_range(0, 59) == 0) begin
        #3 reset = 1'b1;
        #1 check_reset_zero("reset_rand");
        cycles(1);
        #2 reset = 1'b0;
      end
    end
    cycles(2 * (P + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
